// File: rtl/mux16_scan_sampler_if.sv
// Bus between a 16-channel scan sampler and its controller: scan request,
// channel mask, mux select/data and the sample handshake.
interface mux16_scan_sampler_if #(
  parameter int N = 3
);
  logic          start;
  logic [15:0]   mask;
  logic [N-1:0]  mux_out;
  logic          s0;
  logic          s1;
  logic          s2;
  logic          s3;
  logic [N-1:0]  data_out;
  logic [3:0]    chan_id;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport slave (
    input  start, mask, mux_out, out_ready,
    output s0, s1, s2, s3, data_out, chan_id, out_valid, busy, done
  );

  modport master (
    output start, mask, mux_out, out_ready,
    input  s0, s1, s2, s3, data_out, chan_id, out_valid, busy, done
  );
endinterface

// File: rtl/mux16_scan_sampler.sv
// Scans the enabled channels of an external 16:1 mux in ascending order,
// waits SETTLE cycles after each select change, then offers one sample.
module mux16_scan_sampler #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  mux16_scan_sampler_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE_W,
    HOLD,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   mask_r_q, mask_r_d;
  logic [N-1:0]  data_q, data_d;
  logic [3:0]    chan_q, chan_d;
  logic          valid_q, valid_d;
  logic [15:0]   above_mask;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Enabled channels strictly above the current select; lowest of these is next.
  for (genvar gi = 0; gi < 16; gi++) begin : g_above
    assign above_mask[gi] = mask_r_q[gi] && (4'(gi) > sel_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_r_q <= '0;
      data_q   <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_r_q <= mask_r_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_r_d = mask_r_q;
    data_d   = data_q;
    chan_d   = chan_q;
    valid_d  = valid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mask_r_d = bus.mask;
          if (bus.mask == 16'h0000) begin
            state_d = DONE;
          end else begin
            sel_d   = lowest_set(bus.mask);
            cnt_d   = 4'd0;
            state_d = SETTLE_W;
          end
        end
      end

      SETTLE_W: begin
        cnt_d = cnt_q + 4'd1;
        // The capture edge is the one where the counter reaches SETTLE.
        if (({1'b0, cnt_q} + 5'd1) == 5'(SETTLE)) begin
          data_d  = bus.mux_out;
          chan_d  = sel_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          if (|above_mask) begin
            sel_d   = lowest_set(above_mask);
            cnt_d   = 4'd0;
            state_d = SETTLE_W;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s0        = sel_q[0];
  assign bus.s1        = sel_q[1];
  assign bus.s2        = sel_q[2];
  assign bus.s3        = sel_q[3];
  assign bus.data_out  = data_q;
  assign bus.chan_id   = chan_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: doc/mux16_scan_sampler.md
MUX16_SCAN_SAMPLER -- requirements
Module: mux16_scan_sampler

Interface
REQ-001 SHALL have parameter N, default 3: data width of the sampled mux output.
REQ-002 SHALL have parameter SETTLE, default 1, legal range 1..15: cycles the select is held before capture.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  scan request, sampled only in IDLE.
REQ-006 SHALL have port mask  input  16  channel enables, bit k enables channel k; captured at scan start.
REQ-007 SHALL have port mux_out  input  N  data returned by the downstream 16:1 mux for the current select.
REQ-008 SHALL have ports s0, s1, s2, s3  output  1 each  mux select; {s3,s2,s1,s0} = channel index, s0 LSB.
REQ-009 SHALL have port data_out  output  N  captured sample.
REQ-010 SHALL have port chan_id  output  4  channel index of data_out.
REQ-011 SHALL have port out_valid  output  1  data_out/chan_id valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the sample.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at scan end.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE_W, HOLD, DONE.
REQ-016 IDLE: on the edge with start=1, latch mask into mask_r; if mask=0, go to DONE; else load the lowest enabled index into the selects, clear the settle counter, go to SETTLE_W.
REQ-017 SETTLE_W: increment the settle counter each cycle; on the edge where it reaches SETTLE, capture mux_out into data_out and the select value into chan_id, set out_valid, go to HOLD.
REQ-018 out_valid SHALL rise exactly SETTLE cycles after the edge that loaded the select.
REQ-019 HOLD: data_out, chan_id and the selects SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 HOLD: on the edge with out_ready=1, clear out_valid; if a higher enabled index exists in mask_r, load it into the selects and go to SETTLE_W; else go to DONE.
REQ-021 DONE: assert done for exactly one cycle, then return to IDLE; busy SHALL be 1 in DONE.
REQ-022 Channels SHALL be visited in strictly ascending index order, each enabled channel exactly once per scan; disabled channels are skipped with no cycle cost.
REQ-023 Changes on mask after scan start SHALL be ignored until the next scan.
REQ-024 start while busy=1 SHALL be ignored; it is not queued.
REQ-025 Throughput: at most one sample per SETTLE+1 cycles; no back-to-back out_valid across channels.
REQ-026 mux_out is sampled only on the capture edge; glitches at other times SHALL have no effect.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 While rst=1: state=IDLE, selects=0, data_out=0, chan_id=0, out_valid=0, busy=0, done=0, mask_r=0, settle counter=0, effective immediately and without a clock.
REQ-029 Assertion of rst during a scan SHALL abandon it; no done pulse; the first start after deassertion begins a fresh scan.

Verification
REQ-030 SETTLE=1, mask=16'h0005, out_ready=1, mux_out = 3'd(index+1) tracking the selects -> two samples (chan 0, data 1) then (chan 2, data 3), selects 0 then 2, one done pulse, busy low afterwards.
REQ-031 mask=16'h0000, start=1 -> no out_valid, done high exactly one cycle after the start edge, busy high only for that cycle.
REQ-032 mask=16'h8000, out_ready=0 for 5 cycles after out_valid rises -> data_out, chan_id=15 and selects=4'b1111 held steady; transfer on the first ready cycle; done follows.
REQ-033 SETTLE=3, mask=16'hFFFF, out_ready=1 -> 16 samples, chan_id 0..15 ascending, each out_valid exactly 3 cycles after its select change.
REQ-034 rst asserted in HOLD on chan 4 of mask=16'h00F0 -> all outputs 0 immediately, no done; new start with mask=16'h0002 -> single sample on chan 1.
REQ-035 start pulsed and mask changed to 16'h0000 mid-scan of mask=16'h0011 -> scan completes channels 0 and 4 unchanged, second start ignored.
